// File: rtl/ssd_value_selector.sv
// ssd_value_selector: picks one of four 32-bit observation words, saturates it
// to the 13-bit display range and holds it between periodic refresh loads.
// A debounced push-button steps the source; a press forces an immediate load.
module ssd_value_selector #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int UPDATE_CYCLES   = 1_048_576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_next,
    input  logic [31:0] src0,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic [31:0] src3,
    input  logic        hold,
    output logic [12:0] num,
    output logic [1:0]  sel,
    output logic        update_pulse
);

    // The debounce counter only needs to reach DEBOUNCE_CYCLES-1; the +1 keeps
    // the width at least one bit when DEBOUNCE_CYCLES is 1.
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int UW = $clog2(UPDATE_CYCLES);

    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [UW-1:0] UPD_LAST = UW'(UPDATE_CYCLES - 1);

    // Clamp a full 32-bit word into the 13-bit display range.
    function automatic logic [12:0] sat13(input logic [31:0] x);
        logic [12:0] r;
        if (x > 32'd8191) begin
            r = 13'h1FFF;
        end else begin
            r = x[12:0];
        end
        return r;
    endfunction

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q,    stable_d;
    logic [DW-1:0] db_cnt_q,    db_cnt_d;
    logic          stable_dly_q;
    logic [1:0]    sel_q,       sel_d;
    logic          pending_q,   pending_d;
    logic [UW-1:0] upd_cnt_q,   upd_cnt_d;
    logic [12:0]   num_q,       num_d;
    logic          pulse_q;

    logic          press_s;
    logic          tick_s;
    logic          load_s;
    logic [31:0]   src_sel_s;

    // Debouncer: flip the stable state only after a persistent mismatch.
    always_comb begin
        stable_d = stable_q;
        db_cnt_d = '0;
        if (sync2_q != stable_q) begin
            if (db_cnt_q == DB_LAST) begin
                stable_d = sync2_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + DW'(1);
            end
        end else begin
            db_cnt_d = '0;
        end
    end

    assign press_s = stable_q & ~stable_dly_q;
    assign tick_s  = (upd_cnt_q == UPD_LAST);
    // A forced reload and a periodic tick on the same edge merge into one load.
    assign load_s  = (tick_s | pending_q) & ~hold;

    // Source mux, indexed by the current selection.
    always_comb begin
        src_sel_s = 32'd0;
        case (sel_q)
            2'd0:    src_sel_s = src0;
            2'd1:    src_sel_s = src1;
            2'd2:    src_sel_s = src2;
            2'd3:    src_sel_s = src3;
            default: src_sel_s = 32'd0;
        endcase
    end

    // Selection stepping, pending-reload bookkeeping, refresh counter and load.
    always_comb begin
        sel_d     = sel_q;
        pending_d = pending_q;
        upd_cnt_d = upd_cnt_q + UW'(1);
        num_d     = num_q;

        if (press_s) begin
            sel_d     = sel_q + 2'd1;
            pending_d = 1'b1;
        end else if (load_s) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end

        // Any load (periodic or forced) restarts the refresh period.
        if (tick_s || load_s) begin
            upd_cnt_d = '0;
        end else begin
            upd_cnt_d = upd_cnt_q + UW'(1);
        end

        if (load_s) begin
            num_d = sat13(src_sel_s);
        end else begin
            num_d = num_q;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            db_cnt_q     <= '0;
            stable_dly_q <= 1'b0;
            sel_q        <= 2'd0;
            pending_q    <= 1'b0;
            upd_cnt_q    <= '0;
            num_q        <= 13'd0;
            pulse_q      <= 1'b0;
        end else begin
            sync1_q      <= btn_next;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            db_cnt_q     <= db_cnt_d;
            stable_dly_q <= stable_q;
            sel_q        <= sel_d;
            pending_q    <= pending_d;
            upd_cnt_q    <= upd_cnt_d;
            num_q        <= num_d;
            pulse_q      <= load_s;
        end
    end

    assign num          = num_q;
    assign sel          = sel_q;
    assign update_pulse = pulse_q;

endmodule

// File: tb/tb_ssd_value_selector.sv
// Directed self-checking bench for ssd_value_selector (DEBOUNCE=4, UPDATE=8).
module tb_ssd_value_selector;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_next;
    logic [31:0] src0, src1, src2, src3;
    logic        hold;
    logic [12:0] num;
    logic [1:0]  sel;
    logic        update_pulse;

    int n_checks = 0;
    int n_pass   = 0;

    ssd_value_selector #(
        .DEBOUNCE_CYCLES(4),
        .UPDATE_CYCLES  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_next    (btn_next),
        .src0        (src0),
        .src1        (src1),
        .src2        (src2),
        .src3        (src3),
        .hold        (hold),
        .num         (num),
        .sel         (sel),
        .update_pulse(update_pulse)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Compare one observed value against its expectation.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load src0 through one full refresh period, starting right after a load.
    task automatic period_load(input string tag, input logic [31:0] v, input logic [12:0] expv);
        src0 = v;
        step();
        check_val({tag, "_pulse_off"}, {31'd0, update_pulse}, 32'd0);
        repeat (6) step();
        check_val({tag, "_no_early"}, {31'd0, update_pulse}, 32'd0);
        step();
        check_val({tag, "_num"}, {19'd0, num}, {19'd0, expv});
        check_val({tag, "_pulse"}, {31'd0, update_pulse}, 32'd1);
    endtask

    // One clean 10-cycle press followed by 10 low cycles.
    task automatic press();
        btn_next = 1'b1;
        repeat (10) step();
        btn_next = 1'b0;
        repeat (10) step();
    endtask

    int          h_len [6] = '{1, 3, 2, 1, 3, 2};
    int          pulses;
    logic [15:0] pvec;
    logic [1:0]  exp_sel [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
    logic [12:0] exp_num [4] = '{13'd500, 13'd8191, 13'd9, 13'd42};

    initial begin
        rst = 1'b1; btn_next = 1'b0; hold = 1'b0;
        src0 = 32'd1234; src1 = 32'd42; src2 = 32'd500; src3 = 32'd9000;

        // Reset and first periodic load.
        repeat (3) begin
            step();
            check_val("rst_num",   {19'd0, num}, 32'd0);
            check_val("rst_sel",   {30'd0, sel}, 32'd0);
            check_val("rst_pulse", {31'd0, update_pulse}, 32'd0);
        end
        rst = 1'b0;
        repeat (7) step();
        check_val("first_load_not_early", {19'd0, num}, 32'd0);
        step();
        check_val("first_load_num",   {19'd0, num}, 32'd1234);
        check_val("first_load_pulse", {31'd0, update_pulse}, 32'd1);

        // Saturation on the periodic path.
        period_load("sat_8191", 32'd8191,      13'd8191);
        period_load("sat_8192", 32'd8192,      13'd8191);
        period_load("sat_ffff", 32'hFFFF_FFFF, 13'd8191);
        period_load("sat_10005", 32'h0001_0005, 13'd8191);
        period_load("sat_9",    32'd9,         13'd9);

        // Debounced press: E is two edges into a period.
        repeat (2) step();
        btn_next = 1'b1;
        repeat (6) step();
        check_val("press_sel_before", {30'd0, sel}, 32'd0);
        step();
        check_val("press_sel_e6", {30'd0, sel}, 32'd1);
        check_val("press_num_e6", {19'd0, num}, 32'd9);
        step();
        check_val("press_num_e7",   {19'd0, num}, 32'd42);
        check_val("press_pulse_e7", {31'd0, update_pulse}, 32'd1);
        repeat (2) step();
        btn_next = 1'b0;
        repeat (5) begin
            step();
            check_val("press_restart_quiet", {31'd0, update_pulse}, 32'd0);
        end
        step();
        check_val("press_restart_tick", {31'd0, update_pulse}, 32'd1);

        // Four more presses walk sel 2,3,0,1.
        for (int i = 0; i < 4; i++) begin
            press();
            check_val("step_sel", {30'd0, sel}, {30'd0, exp_sel[i]});
            check_val("step_num", {19'd0, num}, {19'd0, exp_num[i]});
        end

        // Bounce rejection, then steady periodic loads only.
        for (int i = 0; i < 6; i++) begin
            btn_next = 1'b1;
            repeat (h_len[i]) begin
                step();
                check_val("bounce_sel_hi", {30'd0, sel}, 32'd1);
            end
            btn_next = 1'b0;
            repeat (2) begin
                step();
                check_val("bounce_sel_lo", {30'd0, sel}, 32'd1);
            end
        end
        pulses = 0;
        repeat (32) begin
            step();
            if (update_pulse) pulses++;
            check_val("bounce_sel_after", {30'd0, sel}, 32'd1);
        end
        check_val("bounce_pulse_count", pulses, 32'd4);

        // Reset mid-operation, then hold.
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("rst2_sel",   {30'd0, sel}, 32'd0);
        check_val("rst2_num",   {19'd0, num}, 32'd0);
        check_val("rst2_pulse", {31'd0, update_pulse}, 32'd0);
        hold = 1'b1;
        src0 = 32'd555; src1 = 32'd77;
        btn_next = 1'b1;
        repeat (10) begin
            step();
            check_val("hold_num",   {19'd0, num}, 32'd0);
            check_val("hold_pulse", {31'd0, update_pulse}, 32'd0);
        end
        btn_next = 1'b0;
        repeat (20) begin
            step();
            check_val("hold_num",   {19'd0, num}, 32'd0);
            check_val("hold_pulse", {31'd0, update_pulse}, 32'd0);
        end
        check_val("hold_sel", {30'd0, sel}, 32'd1);
        hold = 1'b0;
        step();
        check_val("unhold_num",   {19'd0, num}, 32'd77);
        check_val("unhold_pulse", {31'd0, update_pulse}, 32'd1);

        // Press timed so pending-reload lands on the periodic tick.
        btn_next = 1'b1;
        pvec = 16'd0;
        for (int i = 0; i < 16; i++) begin
            step();
            pvec[i] = update_pulse;
            if (i == 9) btn_next = 1'b0;
        end
        check_val("coincide_pulses", {16'd0, pvec}, 32'h0000_8080);
        check_val("coincide_sel",    {30'd0, sel}, 32'd2);
        check_val("coincide_num",    {19'd0, num}, 32'd500);

        // Reset during the third debounce cycle discards the partial count.
        btn_next = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("rst_db_sel_now", {30'd0, sel}, 32'd0);
        repeat (2) step();
        btn_next = 1'b0;
        repeat (12) begin
            step();
            check_val("rst_db_sel", {30'd0, sel}, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ssd_value_selector.md
# ssd_value_selector

Upstream feeder for the four-digit seven-segment driver. It picks one of four 32-bit processor observation words (PC, instruction, register-file read data, cycle count), saturates it to the 13-bit `num` range the driver accepts, and holds it stable between periodic updates so digits do not flicker. The source is chosen by stepping with a debounced push-button. A hold input freezes the display.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive cycles the synchronized button must differ from its debounced state before the state flips (≥1).
- UPDATE_CYCLES, 1_048_576: period, in clk cycles, of the display refresh load (≥2; default equals one full 4-digit scan).

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- btn_next  in  1  raw, asynchronous, bouncing push-button; a press advances the source.
- src0  in  32  PC.
- src1  in  32  fetched instruction.
- src2  in  32  register-file read data.
- src3  in  32  cycle counter.
- hold  in  1  1 = freeze `num`; no loads occur.
- num  out  13  registered display value; drives the driver's `num`.
- sel  out  2  currently selected source index.
- update_pulse  out  1  single-cycle strobe, high the cycle after `num` is loaded.

## Operation

- **Reset values:** all outputs and internal state are 0. This covers `num`, `sel`, `update_pulse`, the two sync flops, the debounced state, the debounce counter, the edge-detect register, the update counter and pending-reload.
- **Synchronizer:** `btn_next` passes through 2 flops to give sync_btn.
- **Debouncer:**
  - While sync_btn ≠ stable, the counter increments.
  - When the counter equals DEBOUNCE_CYCLES−1 and the mismatch persists, stable ← sync_btn and the counter ← 0.
  - Any cycle with sync_btn == stable clears the counter.
- **Press detect:** a registered rising edge of stable increments `sel` modulo 4 (3 wraps to 0) and sets pending-reload. Release edges are ignored.
- **Update counter:**
  - Free-running from 0 to UPDATE_CYCLES−1, then wraps to 0; the wrap edge is the periodic tick.
  - Pending-reload restarts the counter at 0.
- **Load:**
  - A load happens on an edge where (tick or pending-reload) and hold == 0.
  - On a load, `num` ← sat(src[`sel`]) and pending-reload clears.
  - Pending-reload always uses the already-updated `sel`.
- **Saturation:** sat(x) = 13'h1FFF (8191) if x > 8191, else x[12:0]. Compare the full 32 bits; never truncate silently.
- **Hold:**
  - While hold == 1, no load occurs. `sel` still advances and the counter still runs.
  - Pending-reload stays set and is serviced on the first edge with hold == 0.
- **update_pulse:** registered copy of the load-enable, so it is high exactly 1 cycle following each load.

## Timing

- **Button path:** if btn_next is first sampled high at edge E and then stays high:
  - sync_btn = 1 after E+1.
  - stable = 1 at E+1+DEBOUNCE_CYCLES.
  - `sel` increments at E+2+DEBOUNCE_CYCLES.
  - `num` loads at E+3+DEBOUNCE_CYCLES (hold = 0).
  - `update_pulse` is high during the following cycle.
- **Bounce:** a glitch shorter than DEBOUNCE_CYCLES cycles after synchronization produces no `sel` change.
- **Periodic load:** occurs every UPDATE_CYCLES cycles in steady state.
- **Periodic vs. forced load:** a periodic tick coincident with pending-reload produces a single load, and the counter returns to 0.
- **Source change between ticks:** changes on `src*` are invisible on `num` until the next load. Sources are sampled only on the load edge.
- **Reset mid-operation:** reset returns everything to reset values at the next edge. Any pending-reload or partial debounce count is discarded.
- **Latency after reset release:** the first periodic load occurs UPDATE_CYCLES edges after reset deasserts.

## Test plan

All directed tests run with DEBOUNCE_CYCLES = 4 and UPDATE_CYCLES = 8.

- **Reset/periodic load:**
  - Stimulus: assert rst for 3 cycles, with src0 = 1234.
  - Required: `num` = 0, `sel` = 0 and `update_pulse` = 0 during reset.
  - Required after release: `num` = 1234 after the 8th edge, then `update_pulse` = 1 for exactly 1 cycle.
- **Saturation:**
  - Stimulus: src0 = 8191, then 8192, then 32'hFFFF_FFFF.
  - Required: `num` = 8191 for all three after their loads.
  - Stimulus: src0 = 9.
  - Required: `num` = 9.
- **Debounced stepping:**
  - Stimulus: a clean press of 10 cycles, with src1 = 42.
  - Required: `sel` 0→1 at E+6, `num` = 42 at E+7 with no wait for a tick, and the update counter restarts.
  - Stimulus: 4 more presses.
  - Required: `sel` goes 2, 3, 0, 1.
- **Bounce rejection:**
  - Stimulus: btn_next toggles with high pulses of 1–3 cycles for 20 cycles, then stays low.
  - Required: `sel` never changes; `num` is updated only by periodic loads.
- **Hold:**
  - Stimulus: hold = 1, then change src0 and press once (`sel` → 1, with src1 = 77).
  - Required while hold = 1: `num` is unchanged for 30 cycles and `update_pulse` stays 0.
  - Stimulus: deassert hold.
  - Required: `num` = 77 on the next edge.
- **Coincident events/reset mid-debounce:**
  - Stimulus: align pending-reload with a tick.
  - Required: exactly 1 `update_pulse`.
  - Stimulus: assert rst during the 3rd debounce cycle.
  - Required: `sel` stays 0.
